demux32_buf: RTL and testbench

Buffered 1-to-2 demultiplexer for 32-bit datapath words: the routing counterpart of the 2:1 32-bit select mux. It accepts one stream with a valid/ready handshake and steers each word, by a per-word select bit, into one of two independent output FIFOs. Each output drains through its own valid/ready handshake. It sits between a single result producer and two pipeline consumers and absorbs back-pressure without dropping or reordering words per destination.

---
 rtl/demux32_buf.sv | 136 +++++++++++++
 tb/tb_demux32_buf.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/demux32_buf.sv
// rtl/demux32_buf.sv - buffered 1-to-2 demultiplexer with per-destination FIFOs
//
// Steers each accepted input word, by its select bit, into one of two
// independent FIFOs that each drain through their own valid/ready handshake.
//
// Parameters:
//   DEPTH    entries per output FIFO (power of two, 2..16)
//   WIDTH    data width in bits
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_i            synchronous active-high reset
//   data_i           input word
//   select_i         destination: 0 -> output 1, 1 -> output 2
//   valid_i          data_i/select_i valid
//   ready_o          word accepted when high together with valid_i
//   data1_o          head of FIFO 1 (don't-care when empty)
//   valid1_o         FIFO 1 non-empty
//   ready1_i         consumer 1 pops the head
//   data2_o          head of FIFO 2 (don't-care when empty)
//   valid2_o         FIFO 2 non-empty
//   ready2_i         consumer 2 pops the head
//   cnt1_o, cnt2_o   saturating accepted-push counters (only with DEMUX32_STATS_EN)
//
// Optional feature macro: DEMUX32_STATS_EN
module demux32_buf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             select_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] data1_o,
    output logic             valid1_o,
    input  logic             ready1_i,
    output logic [WIDTH-1:0] data2_o,
    output logic             valid2_o,
`ifdef DEMUX32_STATS_EN
    input  logic             ready2_i,
    output logic [15:0]      cnt1_o,
    output logic [15:0]      cnt2_o
`else
    input  logic             ready2_i
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem1 [DEPTH];
    logic [WIDTH-1:0] mem2 [DEPTH];
    logic [AW-1:0]    wr_ptr1, rd_ptr1, wr_ptr2, rd_ptr2;
    logic [CW-1:0]    count1, count2;

    logic push1, push2, pop1, pop2;

    // ready_o depends only on select_i and registered counts, so a pop this
    // cycle never frees a slot for a push in the same cycle.
    always_comb begin
        ready_o  = select_i ? (count2 != FULL_CNT) : (count1 != FULL_CNT);
        valid1_o = (count1 != '0);
        valid2_o = (count2 != '0);
        data1_o  = mem1[rd_ptr1];
        data2_o  = mem2[rd_ptr2];
        push1    = valid_i && ready_o && !select_i;
        push2    = valid_i && ready_o &&  select_i;
        pop1     = valid1_o && ready1_i;
        pop2     = valid2_o && ready2_i;
    end

    // Storage is deliberately not reset; pointers alone define contents.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push1) begin
            mem1[wr_ptr1] <= data_i;
        end
        if (!rst_i && push2) begin
            mem2[wr_ptr2] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr1 <= '0;
            rd_ptr1 <= '0;
            count1  <= '0;
            wr_ptr2 <= '0;
            rd_ptr2 <= '0;
            count2  <= '0;
        end else begin
            if (push1) begin
                wr_ptr1 <= wr_ptr1 + AW'(1);
            end
            if (pop1) begin
                rd_ptr1 <= rd_ptr1 + AW'(1);
            end
            case ({push1, pop1})
                2'b10:   count1 <= count1 + CW'(1);
                2'b01:   count1 <= count1 - CW'(1);
                default: count1 <= count1;
            endcase

            if (push2) begin
                wr_ptr2 <= wr_ptr2 + AW'(1);
            end
            if (pop2) begin
                rd_ptr2 <= rd_ptr2 + AW'(1);
            end
            case ({push2, pop2})
                2'b10:   count2 <= count2 + CW'(1);
                2'b01:   count2 <= count2 - CW'(1);
                default: count2 <= count2;
            endcase
        end
    end

`ifdef DEMUX32_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt1_o <= '0;
            cnt2_o <= '0;
        end else begin
            if (push1 && cnt1_o != 16'hFFFF) begin
                cnt1_o <= cnt1_o + 16'd1;
            end
            if (push2 && cnt2_o != 16'hFFFF) begin
                cnt2_o <= cnt2_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux32_buf.sv
// tb/tb_demux32_buf.sv - self-checking bench for demux32_buf against a queue model
module tb_demux32_buf;

    localparam int DEPTH = 2;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [WIDTH-1:0] data_i;
    logic             select_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data1_o;
    logic             valid1_o;
    logic             ready1_i;
    logic [WIDTH-1:0] data2_o;
    logic             valid2_o;
    logic             ready2_i;
`ifdef DEMUX32_STATS_EN
    logic [15:0]      cnt1_o;
    logic [15:0]      cnt2_o;
`endif

    always #5 clk = ~clk;

    demux32_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .select_i (select_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data1_o  (data1_o),
        .valid1_o (valid1_o),
        .ready1_i (ready1_i),
        .data2_o  (data2_o),
        .valid2_o (valid2_o),
`ifdef DEMUX32_STATS_EN
        .ready2_i (ready2_i),
        .cnt1_o   (cnt1_o),
        .cnt2_o   (cnt2_o)
`else
        .ready2_i (ready2_i)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per destination plus push tallies.
    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] q2[$];
    int               stat1 = 0;
    int               stat2 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, check outputs before the edge, then advance the model.
    task automatic step(input logic r, input logic v, input logic s,
                        input logic [WIDTH-1:0] d, input logic r1, input logic r2);
        logic exp_ready;
        logic do_pop1, do_pop2, do_push;
        @(negedge clk);
        rst_i = r; valid_i = v; select_i = s; data_i = d;
        ready1_i = r1; ready2_i = r2;
        #1;
        exp_ready = s ? (q2.size() != DEPTH) : (q1.size() != DEPTH);
        check("ready_o", {31'd0, ready_o}, {31'd0, exp_ready});
        check("valid1_o", {31'd0, valid1_o}, {31'd0, q1.size() != 0});
        check("valid2_o", {31'd0, valid2_o}, {31'd0, q2.size() != 0});
        if (q1.size() != 0) check("data1_o", data1_o, q1[0]);
        if (q2.size() != 0) check("data2_o", data2_o, q2[0]);
`ifdef DEMUX32_STATS_EN
        check("cnt1_o", {16'd0, cnt1_o}, (stat1 > 65535) ? 32'hFFFF : 32'(stat1));
        check("cnt2_o", {16'd0, cnt2_o}, (stat2 > 65535) ? 32'hFFFF : 32'(stat2));
`endif
        @(posedge clk);
        if (r) begin
            q1.delete();
            q2.delete();
            stat1 = 0;
            stat2 = 0;
        end else begin
            do_pop1 = (q1.size() != 0) && r1;
            do_pop2 = (q2.size() != 0) && r2;
            do_push = v && exp_ready;
            if (do_pop1) void'(q1.pop_front());
            if (do_pop2) void'(q2.pop_front());
            if (do_push) begin
                if (s) begin
                    q2.push_back(d);
                    stat2++;
                end else begin
                    q1.push_back(d);
                    stat1++;
                end
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; select_i = 1'b0; data_i = '0;
        ready1_i = 1'b0; ready2_i = 1'b0;
        repeat (2) @(posedge clk);

        // Idle after reset, both select values.
        step(0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 1, 32'h0, 0, 0);

        // Single words to each output, consumers ready.
        step(0, 1, 0, 32'hDEAD_BEEF, 1, 1);
        step(0, 1, 1, 32'h1234_5678, 1, 1);
        step(0, 0, 0, 32'h0, 1, 1);
        step(0, 0, 0, 32'h0, 1, 1);

        // Fill FIFO 1 with A, B; C refused while full.
        step(0, 1, 0, 32'hAAAA_0001, 0, 0);
        step(0, 1, 0, 32'hBBBB_0002, 0, 0);
        step(0, 1, 0, 32'hCCCC_0003, 0, 0);
        // FIFO 1 still full, select-1 word goes straight through.
        step(0, 1, 1, 32'h2222_0001, 0, 1);
        step(0, 1, 1, 32'h2222_0002, 0, 1);
        // Pop while full: C refused this cycle, accepted next.
        step(0, 1, 0, 32'hCCCC_0003, 1, 1);
        step(0, 1, 0, 32'hCCCC_0003, 1, 1);
        repeat (4) step(0, 0, 0, 32'h0, 1, 1);

        // Fill both, then reset mid-operation.
        step(0, 1, 0, 32'h1111_0001, 0, 0);
        step(0, 1, 0, 32'h1111_0002, 0, 0);
        step(0, 1, 1, 32'h2222_0003, 0, 0);
        step(0, 1, 1, 32'h2222_0004, 0, 0);
        step(1, 1, 0, 32'h5555_5555, 1, 1);
        step(0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 1, 32'h0, 0, 0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1),
                 $urandom,
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) == 0));
        end

`ifdef DEMUX32_STATS_EN
        // Saturation of the push counter.
        step(1, 0, 0, 32'h0, 1, 1);
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            rst_i = 1'b0; valid_i = 1'b1; select_i = 1'b0; data_i = i;
            ready1_i = 1'b1; ready2_i = 1'b1;
        end
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        check("cnt1_sat", {16'd0, cnt1_o}, 32'hFFFF);
        check("cnt2_zero", {16'd0, cnt2_o}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
